// File: rtl/inst_cmd_fetch.sv
// -----------------------------------------------------------------------------
// inst_cmd_fetch
//
// Reader end of the asynchronous instruction BRAM. Walks the command list the
// processor leaves in the BRAM, decodes each header word and turns the command
// into one or more command-stream beats for the graphics pipeline.
//
// Header encoding:
//   bit31 = 1 : payload command, op = hdr[7:0], nargs = hdr[15:8]
//   bit31 = 0 : immediate command (no args), op = hdr[7:0], imm = hdr[15:8]
//   hdr   = 0 : end of list
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, base_addr         one-cycle start pulse and word index of first header
//   addr1 / read0            header read port (addr1 = pc)
//   addr2 / read1..read4     argument burst port (addr2 = argptr, read1 = mem[addr2])
//   cmd_valid / cmd_ready    output beat handshake
//   cmd_op, cmd_imm          opcode and immediate (imm is 0 for payload commands)
//   cmd_nargs                total argument count of the command
//   cmd_data0..cmd_data3     argument lanes, data0 = lowest address
//   cmd_mask                 lane valid mask, bit0 = data0
//   cmd_first, cmd_last      first / last beat of the command
//   busy, done, error        status
// -----------------------------------------------------------------------------
module inst_cmd_fetch #(
   parameter int unsigned MEM_DEPTH = 50,
   parameter int unsigned PC_W      = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [PC_W-1:0] base_addr,
   output logic [PC_W-1:0] addr1,
   output logic [PC_W-1:0] addr2,
   input  logic [31:0]     read0,
   input  logic [31:0]     read1,
   input  logic [31:0]     read2,
   input  logic [31:0]     read3,
   input  logic [31:0]     read4,
   output logic            cmd_valid,
   input  logic            cmd_ready,
   output logic [7:0]      cmd_op,
   output logic [7:0]      cmd_imm,
   output logic [7:0]      cmd_nargs,
   output logic [31:0]     cmd_data0,
   output logic [31:0]     cmd_data1,
   output logic [31:0]     cmd_data2,
   output logic [31:0]     cmd_data3,
   output logic [3:0]      cmd_mask,
   output logic            cmd_first,
   output logic            cmd_last,
   output logic            busy,
   output logic            done,
   output logic            error
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StHdr  = 3'd1;
   localparam logic [2:0] StArgs = 3'd2;
   localparam logic [2:0] StDone = 3'd3;
   localparam logic [2:0] StErr  = 3'd4;

   localparam logic [PC_W-1:0] DepthPc  = PC_W'(MEM_DEPTH);
   // One extra bit so pc + nargs can never wrap before the bounds compare.
   localparam logic [PC_W:0]   DepthExt = (PC_W+1)'(MEM_DEPTH);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [2:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] argptr_q, argptr_d;
   logic [7:0]      remain_q, remain_d;
   logic [7:0]      op_q, op_d;
   logic [7:0]      nargs_q, nargs_d;
   logic            first_pend_q, first_pend_d;

   // Output beat register
   logic             valid_q, valid_d;
   logic [7:0]       beat_op_q, beat_op_d;
   logic [7:0]       beat_imm_q, beat_imm_d;
   logic [7:0]       beat_nargs_q, beat_nargs_d;
   logic [3:0][31:0] beat_data_q, beat_data_d;
   logic [3:0]       beat_mask_q, beat_mask_d;
   logic             beat_first_q, beat_first_d;
   logic             beat_last_q, beat_last_d;

   // ---------------------------------------------------------------------------
   // Header decode
   // ---------------------------------------------------------------------------
   logic            hdr_zero;
   logic            hdr_payload;
   logic [7:0]      hdr_op;
   logic [7:0]      hdr_hi;
   logic [PC_W:0]   hdr_end;
   logic            hdr_bad;
   logic            pc_oob;
   logic            slot_free;
   logic            unused_hdr;

   assign hdr_zero    = (read0 == 32'd0);
   assign hdr_payload = read0[31];
   assign hdr_op      = read0[7:0];
   assign hdr_hi      = read0[15:8];
   assign unused_hdr  = ^read0[30:16];

   // Index of the last argument word; it must still be inside the BRAM.
   assign hdr_end = {1'b0, pc_q} + (PC_W+1)'(hdr_hi);
   assign hdr_bad = (hdr_hi == 8'd0) || (hdr_end >= DepthExt);
   assign pc_oob  = (pc_q >= DepthPc);

   // The beat register may be overwritten when empty or being accepted now.
   assign slot_free = !valid_q || cmd_ready;

   // ---------------------------------------------------------------------------
   // Argument lanes
   // ---------------------------------------------------------------------------
   logic [3:0]       arg_mask;
   logic [3:0][31:0] arg_words;
   logic [3:0][31:0] arg_data;
   logic             arg_last;

   always_comb begin
      arg_mask = 4'b1111;
      if (remain_q < 8'd4) begin
         unique case (remain_q[1:0])
            2'd1:    arg_mask = 4'b0001;
            2'd2:    arg_mask = 4'b0011;
            2'd3:    arg_mask = 4'b0111;
            default: arg_mask = 4'b0000;
         endcase
      end
   end

   always_comb begin
      arg_words[0] = read1;
      arg_words[1] = read2;
      arg_words[2] = read3;
      arg_words[3] = read4;
      // Lanes past the end of the command may read beyond the list; zero them.
      for (int i = 0; i < 4; i++) begin
         arg_data[i] = arg_mask[i] ? arg_words[i] : 32'd0;
      end
   end

   assign arg_last = (remain_q <= 8'd4);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      argptr_d     = argptr_q;
      remain_d     = remain_q;
      op_d         = op_q;
      nargs_d      = nargs_q;
      first_pend_d = first_pend_q;

      valid_d      = valid_q;
      beat_op_d    = beat_op_q;
      beat_imm_d   = beat_imm_q;
      beat_nargs_d = beat_nargs_q;
      beat_data_d  = beat_data_q;
      beat_mask_d  = beat_mask_q;
      beat_first_d = beat_first_q;
      beat_last_d  = beat_last_q;

      // Beat accepted (or slot already empty): drop valid unless reloaded below.
      if (slot_free) begin
         valid_d = 1'b0;
      end

      case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               pc_d    = base_addr;
               state_d = StHdr;
            end
         end

         StHdr: begin
            if (pc_oob) begin
               state_d = StErr;
            end else if (hdr_zero) begin
               state_d = StDone;
            end else if (!hdr_payload) begin
               if (slot_free) begin
                  valid_d      = 1'b1;
                  beat_op_d    = hdr_op;
                  beat_imm_d   = hdr_hi;
                  beat_nargs_d = 8'd0;
                  beat_data_d  = '0;
                  beat_mask_d  = 4'b0000;
                  beat_first_d = 1'b1;
                  beat_last_d  = 1'b1;
                  pc_d         = pc_q + PC_W'(1);
               end
            end else if (hdr_bad) begin
               state_d = StErr;
            end else begin
               // Latch the header; argument fetch does not need the slot yet.
               op_d         = hdr_op;
               nargs_d      = hdr_hi;
               argptr_d     = pc_q + PC_W'(1);
               remain_d     = hdr_hi;
               first_pend_d = 1'b1;
               state_d      = StArgs;
            end
         end

         StArgs: begin
            if (slot_free) begin
               valid_d      = 1'b1;
               beat_op_d    = op_q;
               beat_imm_d   = 8'd0;
               beat_nargs_d = nargs_q;
               beat_data_d  = arg_data;
               beat_mask_d  = arg_mask;
               beat_first_d = first_pend_q;
               beat_last_d  = arg_last;
               argptr_d     = argptr_q + PC_W'(4);
               remain_d     = remain_q - 8'd4;
               first_pend_d = 1'b0;
               if (arg_last) begin
                  pc_d    = pc_q + PC_W'(1) + PC_W'(nargs_q);
                  state_d = StHdr;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         pc_q         <= '0;
         argptr_q     <= '0;
         remain_q     <= 8'd0;
         op_q         <= 8'd0;
         nargs_q      <= 8'd0;
         first_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         argptr_q     <= argptr_d;
         remain_q     <= remain_d;
         op_q         <= op_d;
         nargs_q      <= nargs_d;
         first_pend_q <= first_pend_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         beat_op_q    <= 8'd0;
         beat_imm_q   <= 8'd0;
         beat_nargs_q <= 8'd0;
         beat_data_q  <= '0;
         beat_mask_q  <= 4'b0000;
         beat_first_q <= 1'b0;
         beat_last_q  <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         beat_op_q    <= beat_op_d;
         beat_imm_q   <= beat_imm_d;
         beat_nargs_q <= beat_nargs_d;
         beat_data_q  <= beat_data_d;
         beat_mask_q  <= beat_mask_d;
         beat_first_q <= beat_first_d;
         beat_last_q  <= beat_last_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign addr1     = pc_q;
   assign addr2     = argptr_q;

   assign cmd_valid = valid_q;
   assign cmd_op    = beat_op_q;
   assign cmd_imm   = beat_imm_q;
   assign cmd_nargs = beat_nargs_q;
   assign cmd_data0 = beat_data_q[0];
   assign cmd_data1 = beat_data_q[1];
   assign cmd_data2 = beat_data_q[2];
   assign cmd_data3 = beat_data_q[3];
   assign cmd_mask  = beat_mask_q;
   assign cmd_first = beat_first_q;
   assign cmd_last  = beat_last_q;

   assign busy  = (state_q == StHdr) || (state_q == StArgs);
   // Completion is only reported once the final beat has left the register.
   assign done  = (state_q == StDone) && !valid_q;
   assign error = (state_q == StErr);

endmodule

// File: tb/tb_inst_cmd_fetch.sv
module tb_inst_cmd_fetch;

   localparam int Depth = 50;

   typedef struct packed {
      logic [7:0]       op;
      logic [7:0]       imm;
      logic [7:0]       nargs;
      logic [3:0][31:0] data;
      logic [3:0]       mask;
      logic             first;
      logic             last;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic [31:0] addr1, addr2;
   logic [31:0] read0, read1, read2, read3, read4;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  cmd_op, cmd_imm, cmd_nargs;
   logic [31:0] cmd_data0, cmd_data1, cmd_data2, cmd_data3;
   logic [3:0]  cmd_mask;
   logic        cmd_first, cmd_last;
   logic        busy, done, error;

   logic [31:0] mem [0:63];
   beat_t       exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          beats_seen = 0;
   int          ready_mode = 0;

   inst_cmd_fetch #(
      .MEM_DEPTH (Depth),
      .PC_W      (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .addr1     (addr1),
      .addr2     (addr2),
      .read0     (read0),
      .read1     (read1),
      .read2     (read2),
      .read3     (read3),
      .read4     (read4),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_imm   (cmd_imm),
      .cmd_nargs (cmd_nargs),
      .cmd_data0 (cmd_data0),
      .cmd_data1 (cmd_data1),
      .cmd_data2 (cmd_data2),
      .cmd_data3 (cmd_data3),
      .cmd_mask  (cmd_mask),
      .cmd_first (cmd_first),
      .cmd_last  (cmd_last),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: words past the valid depth read as garbage.
   function automatic logic [31:0] rd(input logic [31:0] a);
      if (a < 32'(Depth)) return mem[a[5:0]];
      return 32'hDEAD_BEEF;
   endfunction

   always_comb begin
      read0 = rd(addr1);
      read1 = rd(addr2);
      read2 = rd(addr2 + 32'd1);
      read3 = rd(addr2 + 32'd2);
      read4 = rd(addr2 + 32'd3);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: walk the list straight from the header rules.
   task automatic model(input int base, output bit exp_done, output bit exp_err);
      int          pc;
      int          n;
      logic [31:0] h;
      beat_t       b;
      pc = base;
      exp_done = 1'b0;
      exp_err = 1'b0;
      forever begin
         if (pc >= Depth) begin exp_err = 1'b1; break; end
         h = mem[pc];
         if (h == 32'd0) begin exp_done = 1'b1; break; end
         if (!h[31]) begin
            b = '0;
            b.op = h[7:0];
            b.imm = h[15:8];
            b.first = 1'b1;
            b.last = 1'b1;
            exp_q.push_back(b);
            pc = pc + 1;
         end else begin
            n = int'(h[15:8]);
            if (n == 0 || pc + n >= Depth) begin exp_err = 1'b1; break; end
            for (int k = 0; k < n; k += 4) begin
               b = '0;
               b.op = h[7:0];
               b.nargs = h[15:8];
               for (int i = 0; i < 4; i++) begin
                  if (k + i < n) begin
                     b.mask[i] = 1'b1;
                     b.data[i] = mem[pc + 1 + k + i];
                  end
               end
               b.first = (k == 0);
               b.last = (k + 4 >= n);
               exp_q.push_back(b);
            end
            pc = pc + 1 + n;
         end
      end
   endtask

   // Downstream ready pattern, changed just after each active edge.
   initial begin
      cmd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       cmd_ready = 1'b1;
            1:       cmd_ready = ~cmd_ready;
            default: cmd_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the scoreboard on every accepted beat, checks stall stability.
   initial begin
      beat_t act;
      beat_t held;
      beat_t e;
      bit    hold;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            hold = 1'b0;
         end else begin
            act.op = cmd_op;
            act.imm = cmd_imm;
            act.nargs = cmd_nargs;
            act.data[0] = cmd_data0;
            act.data[1] = cmd_data1;
            act.data[2] = cmd_data2;
            act.data[3] = cmd_data3;
            act.mask = cmd_mask;
            act.first = cmd_first;
            act.last = cmd_last;
            if (hold) begin
               checks++;
               if (!cmd_valid || act !== held) begin
                  errors++;
                  $display("FAIL stall_stable: got v=%b %h expected v=1 %h", cmd_valid, act, held);
               end
            end
            if (cmd_valid && cmd_ready) begin
               beats_seen++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: got %h expected none", act);
               end else begin
                  e = exp_q.pop_front();
                  if (act !== e) begin
                     errors++;
                     $display("FAIL beat %0d: got %h expected %h", beats_seen, act, e);
                  end
               end
               hold = 1'b0;
            end else if (cmd_valid) begin
               hold = 1'b1;
               held = act;
            end else begin
               hold = 1'b0;
            end
         end
      end
   end

   task automatic pulse_start(input int base);
      @(negedge clk);
      base_addr = 32'(base);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Run one list to completion; lat > 0 also checks first-beat latency.
   task automatic run_list(input int base, input int lat, input string name);
      bit exp_done;
      bit exp_err;
      int n;
      exp_q.delete();
      model(base, exp_done, exp_err);
      pulse_start(base);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk);
         #1;
         chk({name, "_latency"}, 32'(cmd_valid), 32'(k == lat));
      end
      n = 0;
      while (!((done || error) && !cmd_valid) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_timeout"}, 32'(n < 3000), 32'd1);
      chk({name, "_done"}, 32'(done), 32'(exp_done));
      chk({name, "_error"}, 32'(error), 32'(exp_err));
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
   endtask

   task automatic load_color_vertex(input int b);
      mem[b + 0] = 32'h8000_0304;
      mem[b + 1] = 32'h3F80_0000;
      mem[b + 2] = 32'h0000_0000;
      mem[b + 3] = 32'h0000_0000;
      mem[b + 4] = 32'h8000_0303;
      mem[b + 5] = 32'h3F80_0000;
      mem[b + 6] = 32'h4120_0000;
      mem[b + 7] = 32'h0000_0000;
      mem[b + 8] = 32'h0000_0000;
   endtask

   task automatic load_rotate();
      mem[0] = 32'h8000_1011;
      for (int i = 1; i <= 16; i++) mem[i] = $urandom;
      mem[17] = 32'h0000_0207;
      mem[18] = 32'h0000_0000;
   endtask

   task automatic gen_random(output int base);
      int pc;
      int r;
      int n;
      fill_random();
      base = $urandom_range(0, 10);
      pc = base;
      while (pc < Depth) begin
         r = $urandom_range(0, 99);
         if (r < 6) begin
            mem[pc] = 32'd0;
            break;
         end else if (r < 35) begin
            mem[pc] = {1'b0, 15'($urandom), 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255))};
            pc = pc + 1;
         end else if (r < 38) begin
            mem[pc] = {1'b1, 15'($urandom), 8'h00, 8'($urandom_range(0, 255))};
            break;
         end else begin
            n = $urandom_range(1, 12);
            mem[pc] = {1'b1, 15'($urandom), 8'(n), 8'($urandom_range(0, 255))};
            pc = pc + 1 + n;
         end
      end
   endtask

   initial begin
      int base;
      int n;
      int b0;
      bit d_exp;
      bit e_exp;
      rst = 1'b0;
      start = 1'b0;
      base_addr = 32'd0;
      fill_random();

      // Reset state
      #12;
      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_addr1", addr1, 32'd0);
      chk("rst_addr2", addr2, 32'd0);
      chk("rst_op", 32'(cmd_op), 32'd0);
      chk("rst_mask", 32'(cmd_mask), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Color + Vertex, always ready
      ready_mode = 0;
      fill_random();
      load_color_vertex(0);
      run_list(0, 2, "cv");

      // Rotate: 16 args, then an immediate at pc 17
      fill_random();
      load_rotate();
      run_list(0, 2, "rot");

      // Immediate + Flush
      fill_random();
      mem[20] = 32'h0000_0110;
      mem[21] = 32'h0000_0005;
      mem[22] = 32'h0000_0000;
      run_list(20, 1, "imm");

      // Color + Vertex with ready toggling
      ready_mode = 1;
      fill_random();
      load_color_vertex(3);
      run_list(3, 2, "cv_tog");
      ready_mode = 0;

      // Argument range overruns the BRAM
      fill_random();
      mem[47] = 32'h8000_0304;
      run_list(47, 0, "oob_args");

      // Zero-argument payload header
      fill_random();
      mem[10] = 32'h8000_0004;
      run_list(10, 0, "nargs0");

      // Header index itself past the end
      run_list(50, 0, "oob_pc");

      // Last argument exactly on the final word
      fill_random();
      mem[46] = 32'h8000_0309;
      run_list(46, 0, "edge_args");

      // Randomised lists and ready patterns
      for (int t = 0; t < 30; t++) begin
         ready_mode = $urandom_range(0, 2);
         gen_random(base);
         run_list(base, 0, "rand");
      end

      // Reset in the middle of a rotate while a beat is valid
      ready_mode = 0;
      fill_random();
      load_rotate();
      exp_q.delete();
      model(0, d_exp, e_exp);
      b0 = beats_seen;
      pulse_start(0);
      n = 0;
      while (beats_seen < b0 + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("mid_wait", 32'(n < 200), 32'd1);
      @(posedge clk);
      #3;
      chk("mid_valid_before", 32'(cmd_valid), 32'd1);
      rst = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_valid", 32'(cmd_valid), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_done", 32'(done), 32'd0);
      chk("mid_error", 32'(error), 32'd0);
      chk("mid_op", 32'(cmd_op), 32'd0);
      chk("mid_nargs", 32'(cmd_nargs), 32'd0);
      chk("mid_data0", cmd_data0, 32'd0);
      chk("mid_mask", 32'(cmd_mask), 32'd0);
      chk("mid_first", 32'(cmd_first), 32'd0);
      chk("mid_last", 32'(cmd_last), 32'd0);
      chk("mid_addr1", addr1, 32'd0);
      chk("mid_addr2", addr2, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_list(0, 2, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
